// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: the EX payload bundle
// and the Jump field encodings.
package ex_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int JUMP_W     = 2;

    localparam logic [JUMP_W-1:0] JUMP_NONE = 2'd0;
    localparam logic [JUMP_W-1:0] JUMP_J    = 2'd1;
    localparam logic [JUMP_W-1:0] JUMP_JR   = 2'd2;
    localparam logic [JUMP_W-1:0] JUMP_JAL  = 2'd3;

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     instruction;
        logic                  reg_write;
        logic                  reg_dst;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [JUMP_W-1:0]     jump;
        logic [DATA_W-1:0]     alu_out;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  halt;
    } ex_mem_payload_t;

    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/ex_mem_pipe_slot.sv
// One pipeline storage slot: payload register plus valid bit.
// Clear wins over load; a cleared slot keeps its stale payload.
module pipe_slot
    import ex_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  ex_mem_payload_t d,
    output ex_mem_payload_t q,
    output logic            valid
);

    ex_mem_payload_t q_reg;
    logic            valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            q_reg     <= d;
            valid_reg <= 1'b1;
        end
    end

    assign q     = q_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid
// buffer, flush and sticky halt tracking.
module ex_mem_pipe
    import ex_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  ex_mem_payload_t in_payload,
    output logic            out_valid,
    input  logic            out_ready,
    output ex_mem_payload_t out_payload,
    output logic [1:0]      occupancy,
    output logic            halted
);

    localparam int MAIN = 0;
    localparam int SKID = 1;

    logic            slot_load  [2];
    logic            slot_clear [2];
    ex_mem_payload_t slot_d     [2];
    ex_mem_payload_t slot_q     [2];
    logic            slot_valid [2];

    logic halt_pending_reg;
    logic halted_reg;
    logic acc;
    logic pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            pipe_slot u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (slot_load[gi]),
                .clear (slot_clear[gi]),
                .d     (slot_d[gi]),
                .q     (slot_q[gi]),
                .valid (slot_valid[gi])
            );
        end
    endgenerate

    // Ready depends only on registered state, so there is no in->out comb path.
    assign in_ready = !slot_valid[SKID] && !halt_pending_reg;
    assign acc      = in_valid && in_ready;
    assign pop      = slot_valid[MAIN] && out_ready;

    always_comb begin
        slot_load[MAIN]  = 1'b0;
        slot_load[SKID]  = 1'b0;
        slot_clear[MAIN] = 1'b0;
        slot_clear[SKID] = 1'b0;
        slot_d[MAIN]     = in_payload;
        slot_d[SKID]     = in_payload;
        if (flush) begin
            slot_clear[MAIN] = 1'b1;
            slot_clear[SKID] = 1'b1;
        end else if (!slot_valid[MAIN]) begin
            slot_load[MAIN] = acc;
        end else if (pop) begin
            if (slot_valid[SKID]) begin
                slot_load[MAIN]  = 1'b1;
                slot_d[MAIN]     = slot_q[SKID];
                slot_clear[SKID] = 1'b1;
            end else if (acc) begin
                slot_load[MAIN] = 1'b1;
            end else begin
                slot_clear[MAIN] = 1'b1;
            end
        end else begin
            slot_load[SKID] = acc;
        end
    end

    // halted survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pending_reg <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            if (flush) begin
                halt_pending_reg <= 1'b0;
            end else if (acc && in_payload.halt) begin
                halt_pending_reg <= 1'b1;
            end
            if (pop && slot_q[MAIN].halt) begin
                halted_reg <= 1'b1;
            end
        end
    end

    assign out_valid   = slot_valid[MAIN];
    assign out_payload = slot_q[MAIN];
    assign occupancy   = count_valid(slot_valid[MAIN], slot_valid[SKID]);
    assign halted      = halted_reg;

endmodule
